// File: rtl/ahb_bus_arbiter_if.sv
// Shared-bus view of the AHB-lite arbiter: master request/lock lines and muxed
// transfer control in, grant and owner IDs out.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MASTER_ID_W = 2
);
  // Handshake: a transfer (HTRANS/HBURST) is accepted on a rising HCLK edge
  // where HREADY=1; with HREADY=0 nothing is consumed and all arbiter state holds.
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MASTER_ID_W-1:0] HMASTER;
  logic [MASTER_ID_W-1:0] HMASTER_DATA;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-lite bus arbiter that holds ownership across fixed-length
// bursts and locked sequences.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MASTER_ID_W = 2
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_bus_arbiter_if.slave  bus,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  state_t                 state_q, state_d;
  logic [4:0]             beats_q, beats_d;
  logic [MASTER_ID_W-1:0] rr_ptr_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MASTER_ID_W-1:0] hmaster_q;
  logic [MASTER_ID_W-1:0] hmaster_data_q;
  logic                   mastlock_q;

  logic [4:0]             burst_len;
  logic                   fixed_burst;
  logic                   incr_burst;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   rearb;
  logic                   winner_found;
  logic [MASTER_ID_W-1:0] winner_id;

  // INCR has no defined length and is encoded as 0 here.
  always_comb begin
    case (bus.HBURST)
      3'd0:          burst_len = 5'd1;
      3'd2, 3'd3:    burst_len = 5'd4;
      3'd4, 3'd5:    burst_len = 5'd8;
      3'd6, 3'd7:    burst_len = 5'd16;
      default:       burst_len = 5'd0;
    endcase
  end

  assign fixed_burst = (burst_len > 5'd1);
  assign incr_burst  = (bus.HBURST == 3'd1);
  assign owner_req   = bus.HBUSREQ[hmaster_q];
  assign owner_lock  = bus.HLOCK[hmaster_q];

  always_comb begin
    rearb = (bus.HTRANS == TR_IDLE)
         || ((bus.HTRANS == TR_NONSEQ) && (burst_len == 5'd1))
         || ((bus.HTRANS == TR_SEQ) && fixed_burst && (beats_q == 5'd1))
         || (incr_burst && !owner_req && (bus.HTRANS != TR_IDLE));
    if (owner_lock) rearb = 1'b0;
  end

  always_comb begin
    beats_d = beats_q;
    if (bus.HTRANS == TR_NONSEQ)
      beats_d = (burst_len == 5'd0) ? 5'd0 : burst_len - 5'd1;
    else if ((bus.HTRANS == TR_SEQ) && (beats_q != 5'd0))
      beats_d = beats_q - 5'd1;
  end

  always_comb begin
    state_d = state_q;
    if (owner_lock) begin
      state_d = ST_LOCKED;
    end else begin
      case (bus.HTRANS)
        TR_IDLE:           state_d = ST_ARB;
        TR_NONSEQ, TR_SEQ: state_d = (beats_d != 5'd0) ? ST_BURST : ST_ARB;
        default: begin
          // BUSY keeps the burst status, except when leaving a lock.
          if (state_q == ST_LOCKED)
            state_d = (beats_q != 5'd0) ? ST_BURST : ST_ARB;
        end
      endcase
    end
  end

  // Search order starts at rr_ptr and wraps; first requester wins.
  always_comb begin
    winner_found = 1'b0;
    winner_id    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!winner_found && bus.HBUSREQ[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
        winner_found = 1'b1;
        winner_id    = MASTER_ID_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q        <= ST_ARB;
      beats_q        <= 5'd0;
      rr_ptr_q       <= MASTER_ID_W'(1);
      grant_q        <= NUM_MASTERS'(1);
      hmaster_q      <= '0;
      hmaster_data_q <= '0;
      mastlock_q     <= 1'b0;
    end else if (bus.HREADY) begin
      state_q        <= state_d;
      beats_q        <= beats_d;
      hmaster_data_q <= hmaster_q;
      mastlock_q     <= owner_lock;
      if (rearb) begin
        // With no requester the bus parks on master 0 and the pointer holds.
        grant_q   <= NUM_MASTERS'(1) << winner_id;
        hmaster_q <= winner_id;
        if (winner_found)
          rr_ptr_q <= MASTER_ID_W'((int'(winner_id) + 1) % NUM_MASTERS);
      end
    end
  end

  assign bus.HGRANT       = grant_q;
  assign bus.HMASTER      = hmaster_q;
  assign bus.HMASTER_DATA = hmaster_data_q;
  assign bus.HMASTLOCK    = mastlock_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios plus random traffic
// checked against a behavioural ownership model.
module tb_ahb_bus_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = N + 2 * IDW + 1;

  logic HCLK = 1'b0;
  logic HRESET;
  logic [1:0] dbg_state;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MASTER_ID_W(IDW)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MASTER_ID_W(IDW)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: who owns the address phase, who owns the data phase,
  // where the round-robin search starts, and how many fixed beats remain.
  int m_owner, m_data, m_rr, m_beats;
  bit m_lock;

  function automatic int len_of(input logic [2:0] b);
    case (b)
      3'd0: return 1;
      3'd1: return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lock,
                            input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    int len;
    bit rearb;
    bit olock;
    int prev_owner;
    if (rst) begin
      m_owner = 0; m_data = 0; m_rr = 1; m_beats = 0; m_lock = 0;
      return;
    end
    if (!ready) return;
    len   = len_of(burst);
    olock = lock[m_owner];
    rearb = (trans == 2'd0) || (trans == 2'd2 && len == 1) ||
            (trans == 2'd3 && len > 1 && m_beats == 1) ||
            (burst == 3'd1 && !req[m_owner] && trans != 2'd0);
    if (olock) rearb = 0;
    prev_owner = m_owner;
    if (trans == 2'd2) m_beats = (len == 0) ? 0 : len - 1;
    else if (trans == 2'd3 && m_beats > 0) m_beats = m_beats - 1;
    if (rearb) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
      if (w < 0) m_owner = 0;
      else begin
        m_owner = w;
        m_rr = (w + 1) % N;
      end
    end
    m_data = prev_owner;
    m_lock = olock;
  endtask

  function automatic logic [W-1:0] model_out();
    logic [N-1:0] g;
    g = '0;
    g[m_owner] = 1'b1;
    return {g, IDW'(m_owner), IDW'(m_data), m_lock};
  endfunction

  // Drive one clock's inputs, predict the post-edge outputs, then take the edge.
  task automatic step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst, input logic ready);
    HRESET       = rst;
    bus.HBUSREQ  = req;
    bus.HLOCK    = lock;
    bus.HTRANS   = trans;
    bus.HBURST   = burst;
    bus.HREADY   = ready;
    model_edge(rst, req, lock, trans, burst, ready);
    exp_q.push_back(model_out());
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] req);
    step(1'b1, req, '0, 2'd0, 3'd0, 1'b1);
    step(1'b1, req, '0, 2'd0, 3'd0, 1'b1);
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      n_compared++;
      if (a !== e) begin
        n_mismatched++;
        $display("FAIL owner_check t=%0t got grant=%b hmaster=%0d hmaster_data=%0d mastlock=%b want grant=%b hmaster=%0d hmaster_data=%0d mastlock=%b",
                 $time, a[W-1 -: N], a[2*IDW -: IDW], a[IDW -: IDW], a[0],
                 e[W-1 -: N], e[2*IDW -: IDW], e[IDW -: IDW], e[0]);
      end
    end
  end

  initial begin
    // Reset with everyone requesting
    do_reset(4'b1111);

    // Round-robin rotation among masters 1..3 with SINGLE transfers
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1110, '0, 2'd2, 3'd0, 1'b1);

    // INCR4 from master 2 with two wait states during beat 2, master 1 waiting
    do_reset('0);
    step(1'b0, 4'b0100, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0110, '0, 2'd2, 3'd3, 1'b1);
    step(1'b0, 4'b0110, '0, 2'd3, 3'd3, 1'b0);
    step(1'b0, 4'b0110, '0, 2'd3, 3'd3, 1'b0);
    step(1'b0, 4'b0110, '0, 2'd3, 3'd3, 1'b1);
    step(1'b0, 4'b0110, '0, 2'd3, 3'd3, 1'b1);
    step(1'b0, 4'b0110, '0, 2'd3, 3'd3, 1'b1);
    step(1'b0, 4'b0010, '0, 2'd2, 3'd0, 1'b1);

    // Locked sequence by master 3 while master 0 requests
    do_reset('0);
    step(1'b0, 4'b1000, '0, 2'd0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1001, 4'b1000, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0001, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0001, '0, 2'd0, 3'd0, 1'b1);

    // Park, then undefined-length INCR released early by master 1
    do_reset('0);
    step(1'b0, '0, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, '0, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0110, '0, 2'd2, 3'd1, 1'b1);
    step(1'b0, 4'b0110, '0, 2'd3, 3'd1, 1'b1);
    step(1'b0, 4'b0100, '0, 2'd3, 3'd1, 1'b1);
    step(1'b0, 4'b0100, '0, 2'd2, 3'd0, 1'b1);

    // Reset during beat 2 of INCR8, then a SINGLE from master 1
    do_reset('0);
    step(1'b0, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0010, '0, 2'd2, 3'd5, 1'b1);
    step(1'b1, 4'b0010, '0, 2'd3, 3'd5, 1'b1);
    step(1'b0, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    step(1'b0, 4'b0010, '0, 2'd2, 3'd0, 1'b1);
    step(1'b0, 4'b0000, '0, 2'd0, 3'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] req, lock;
      req  = N'($urandom);
      lock = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      step(($urandom_range(0, 199) == 0), req, lock,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
    end

    repeat (3) @(negedge HCLK);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain_check pending=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin arbiter that shares one AHB-lite slave-side bus among `NUM_MASTERS` requesting masters. It sits between the master request/lock lines and the master-to-slave address/data muxes. It drives the one-hot grant and the address-phase owner ID that select the address mux, plus the data-phase owner ID that selects the write-data mux and routes the response. It tracks fixed-length bursts and locked sequences so that ownership never changes mid-burst or inside a locked transfer.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesting masters, 2 to 16.
- `MASTER_ID_W`, default 2: width of master ID, equal to `$clog2(NUM_MASTERS)`.

Ports:
- `HCLK` input 1: bus clock; all state updates on the rising edge.
- `HRESET` input 1: reset; synchronous, active-high.
- `HBUSREQ` input `NUM_MASTERS`: per-master bus request.
- `HLOCK` input `NUM_MASTERS`: per-master lock request.
- `HTRANS` input 2: muxed transfer type on the shared bus. IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HBURST` input 3: muxed burst type. SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- `HREADY` input 1: shared ready; a transfer is accepted on a rising edge where it is 1.
- `HGRANT` output `NUM_MASTERS`: one-hot grant, registered.
- `HMASTER` output `MASTER_ID_W`: address-phase owner ID, registered; always the encoding of `HGRANT`.
- `HMASTER_DATA` output `MASTER_ID_W`: data-phase owner ID, registered.
- `HMASTLOCK` output 1: current address phase belongs to a locked sequence, registered.

## Operation
- **Reset values.** `HGRANT`=1 (master 0), `HMASTER`=0, `HMASTER_DATA`=0, `HMASTLOCK`=0, state=ARB, `beats_left`=0, `rr_ptr`=1.
- **Accepted edge.** A rising edge with `HREADY`=1.
- **Burst length.**
  - SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
  - INCR is treated as undefined length.
- **`beats_left` counter.** 5-bit.
  - Accepted NONSEQ loads `len-1`.
  - Accepted SEQ decrements it; the counter saturates at 0.
  - BUSY and IDLE leave it unchanged.
- **States.**
  - ARB: no fixed burst in flight.
  - BURST: a fixed burst has beats remaining.
  - LOCKED: the owner holds `HLOCK`.
- **Re-arbitration point.** An accepted edge where any of the following holds:
  - `HTRANS`=IDLE; or
  - NONSEQ with len=1; or
  - SEQ with `beats_left`=1 in a fixed burst; or
  - `HBURST`=INCR with `HBUSREQ[HMASTER]`=0 (NONSEQ, SEQ or BUSY).

  Re-arbitration is always blocked while `HLOCK[HMASTER]`=1.
- **Transitions.**
  - ARB→BURST: accepted NONSEQ with len>1.
  - BURST→ARB: final beat accepted, or early termination (accepted IDLE, or a new NONSEQ, which reloads the counter).
  - any→LOCKED: `HLOCK[HMASTER]`=1 on an accepted edge.
  - LOCKED→ARB or BURST: `HLOCK[HMASTER]`=0 on an accepted edge, chosen by burst status.
- **Winner selection at a re-arbitration point.**
  - Search `HBUSREQ` starting at index `rr_ptr`, incrementing and wrapping mod `NUM_MASTERS`. The first requester wins.
  - If there are no requests, park on master 0.
  - `rr_ptr` becomes winner+1 mod `NUM_MASTERS` only when the winner was an actual requester.
  - The current owner may win again if it is the first requester in search order.
- **`HMASTLOCK`.** Loads `HLOCK` of the address-phase owner, i.e. `HLOCK[HMASTER]`, on every accepted edge.

## Timing
- Grant latency: `HGRANT`/`HMASTER` change on the re-arbitration edge itself. The new owner drives its first address phase in the following cycle.
- `HMASTER_DATA` loads the previous `HMASTER` on every accepted edge. It therefore lags `HMASTER` by exactly one accepted transfer.
- `HREADY`=0 freezes every register: grant, owner IDs, state, counter, pointer and lock.
- Request changes while `HREADY`=0 have no effect until the next accepted edge.
- `HRESET` overrides all other inputs on the same edge, including mid-burst and mid-lock. All outputs hold their reset values in the cycle after that edge.

## Test plan
- **Reset.** Hold `HRESET`=1 for 2 cycles with all `HBUSREQ`=1 → `HGRANT`=4'b0001, `HMASTER`=0, `HMASTER_DATA`=0, `HMASTLOCK`=0.
- **Round-robin rotation.** Masters 1–3 request continuously, each issuing SINGLE NONSEQ, `HREADY`=1 → `HMASTER` sequence 1,2,3,1,2 with one change per cycle; `HMASTER_DATA` sequence 0,1,2,3,1.
- **Fixed burst with wait states.** Master 2 issues INCR4 while master 1 requests; `HREADY`=0 for 2 cycles during beat 2 → `HMASTER` stays 2 until the edge accepting beat 4, then becomes 1. `HMASTER_DATA` stays 2 for one more accepted edge.
- **Locked sequence.** Master 3 holds `HLOCK`=1 across IDLE cycles while master 0 requests → `HGRANT`=4'b1000 and `HMASTLOCK`=1 throughout. After `HLOCK` drops, the first accepted IDLE grants master 0.
- **Park and undefined INCR.**
  - No requests → `HMASTER`=0.
  - Master 1 runs INCR and deasserts `HBUSREQ` at beat 3 while master 2 requests → grant moves to 2 on the beat-3 accepted edge.
- **Reset mid-burst.** Assert `HRESET` during beat 2 of INCR8 → reset values on the next cycle; a following SINGLE from master 1 is granted without leftover burst blocking.
